// File: rtl/imem_prefetch_buf.sv
// -----------------------------------------------------------------------------
// imem_prefetch_buf
//
// Bridge between the instruction cache refill port and the external
// instruction bus. It runs one bus transaction at a time. After serving a
// word it fetches the next sequential word into a one-entry prefetch buffer,
// so a straight-line refill can be answered in a single cycle. It also keeps
// saturating counters of buffer hits and demand misses.
//
// Parameters
//   PREFETCH_EN  1: fetch the next word after each refill; 0: demand only
//   XLEN         address / data width
//
// Ports
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_DataReq, i_Addr       refill request; held stable until o_MemReady
//   o_Data, o_MemReady      refill data, valid during the one-cycle pulse
//   i_flush                 invalidate the prefetch buffer (FENCE.I)
//   o_BusReq, o_BusAddr     registered bus request and word address
//   i_BusAck, i_BusData     bus completion and read data, same cycle
//   o_hit_cnt, o_miss_cnt   refills served from the buffer / from the bus
// -----------------------------------------------------------------------------
module imem_prefetch_buf #(
   parameter bit PREFETCH_EN = 1'b1,
   parameter int XLEN        = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_DataReq,
   input  logic [XLEN-1:0] i_Addr,
   output logic [XLEN-1:0] o_Data,
   output logic            o_MemReady,
   input  logic            i_flush,
   output logic            o_BusReq,
   output logic [XLEN-1:0] o_BusAddr,
   input  logic            i_BusAck,
   input  logic [XLEN-1:0] i_BusData,
   output logic [31:0]     o_hit_cnt,
   output logic [31:0]     o_miss_cnt
);

   typedef enum logic [1:0] {IDLE, DEMAND, PREFETCH, RESP} state_t;

   state_t          state, state_nxt;
   logic            buf_valid, buf_valid_nxt;
   logic [XLEN-1:2] buf_addr;
   logic [XLEN-1:0] buf_data;
   logic            buf_load;
   logic            drop, drop_nxt;
   logic            mem_ready_nxt;
   logic [XLEN-1:0] data_nxt;
   logic            bus_req_nxt;
   logic [XLEN-1:0] bus_addr_nxt;
   logic            hit_inc, miss_inc;
   logic            hit, pf_match;
   logic [XLEN-1:0] req_word;
   logic            unused_addr_bits;

   // Byte offset of the request is meaningless for word fetches.
   assign unused_addr_bits = ^i_Addr[1:0];
   assign req_word         = {i_Addr[XLEN-1:2], 2'b00};

   // A flush in the same cycle as the request always wins over a hit.
   assign hit      = buf_valid && (buf_addr == i_Addr[XLEN-1:2]) && !i_flush;
   // Address of the prefetch in flight matches the pending request.
   assign pf_match = (o_BusAddr[XLEN-1:2] == i_Addr[XLEN-1:2]);

   // NOTE: every variable is given a default before the case statement so
   // no path leaves one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt     = state;
      mem_ready_nxt = 1'b0;
      data_nxt      = o_Data;
      bus_req_nxt   = o_BusReq;
      bus_addr_nxt  = o_BusAddr;
      buf_valid_nxt = buf_valid && !i_flush;
      buf_load      = 1'b0;
      drop_nxt      = drop;
      hit_inc       = 1'b0;
      miss_inc      = 1'b0;

      unique case (state)
         IDLE: begin
            if (i_DataReq) begin
               // Served address is parked in o_BusAddr (bus idle here) so
               // RESP can derive the next prefetch address from it.
               bus_addr_nxt = req_word;
               if (hit) begin
                  state_nxt     = RESP;
                  mem_ready_nxt = 1'b1;
                  data_nxt      = buf_data;
                  hit_inc       = 1'b1;
               end else begin
                  state_nxt   = DEMAND;
                  bus_req_nxt = 1'b1;
                  miss_inc    = 1'b1;
               end
            end
         end

         DEMAND: begin
            if (i_BusAck) begin
               state_nxt     = RESP;
               mem_ready_nxt = 1'b1;
               data_nxt      = i_BusData;
               bus_req_nxt   = 1'b0;
               buf_valid_nxt = 1'b0;
            end
         end

         RESP: begin
            if (PREFETCH_EN) begin
               state_nxt    = PREFETCH;
               bus_req_nxt  = 1'b1;
               bus_addr_nxt = o_BusAddr + XLEN'(4);
               drop_nxt     = 1'b0;
            end else begin
               state_nxt = IDLE;
            end
         end

         PREFETCH: begin
            if (i_flush) drop_nxt = 1'b1;
            if (i_BusAck) begin
               bus_req_nxt = 1'b0;
               drop_nxt    = 1'b0;
               state_nxt   = IDLE;
               // A flush seen at any point of this transaction, including
               // the ack cycle itself, discards the returning word.
               if (!(drop || i_flush)) begin
                  buf_load      = 1'b1;
                  buf_valid_nxt = 1'b1;
                  if (i_DataReq && pf_match) begin
                     state_nxt     = RESP;
                     mem_ready_nxt = 1'b1;
                     data_nxt      = i_BusData;
                     hit_inc       = 1'b1;
                  end
               end
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: all state is updated with non-blocking assignments so every
   // register samples the values from before the edge.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= IDLE;
         o_MemReady <= 1'b0;
         o_Data     <= '0;
         o_BusReq   <= 1'b0;
         o_BusAddr  <= '0;
         buf_valid  <= 1'b0;
         drop       <= 1'b0;
         o_hit_cnt  <= '0;
         o_miss_cnt <= '0;
      end else begin
         state      <= state_nxt;
         o_MemReady <= mem_ready_nxt;
         o_Data     <= data_nxt;
         o_BusReq   <= bus_req_nxt;
         o_BusAddr  <= bus_addr_nxt;
         buf_valid  <= buf_valid_nxt;
         drop       <= drop_nxt;
         if (hit_inc && (o_hit_cnt != '1))
            o_hit_cnt <= o_hit_cnt + 32'd1;
         if (miss_inc && (o_miss_cnt != '1))
            o_miss_cnt <= o_miss_cnt + 32'd1;
      end
   end

   // NOTE: the buffer payload has no reset; buf_valid alone qualifies it,
   // so resetting the data and address would only add reset fan-out.
   always_ff @(posedge i_clk) begin
      if (buf_load) begin
         buf_addr <= o_BusAddr[XLEN-1:2];
         buf_data <= i_BusData;
      end
   end

endmodule

// File: doc/imem_prefetch_buf.md
# imem_prefetch_buf

Instruction-side memory bridge between the instruction cache's memory port (the cache's data request, address, data block and memory-ready signals) and the external instruction bus. It services cache refills with single-outstanding bus transactions. After each served word, it speculatively fetches the next sequential word (address + 4) into a one-entry prefetch buffer, so straight-line code misses in the cache can be answered in one cycle. It also counts prefetch hits and misses for performance analysis.

## Interface
Parameters:
- PREFETCH_EN, 1: 1 enables next-word prefetch; 0 makes the block a pure demand bridge (buffer never loaded).
- XLEN, `XLEN: data/address width (32).

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_DataReq  input  1  cache refill request; held high with i_Addr stable until o_MemReady.
- i_Addr  input  XLEN  requested word address; bits [1:0] ignored.
- o_Data  output  XLEN  refill data; valid while o_MemReady=1.
- o_MemReady  output  1  one-cycle pulse completing the current refill.
- i_flush  input  1  invalidate the prefetch buffer (FENCE.I).
- o_BusReq  output  1  bus request; registered.
- o_BusAddr  output  XLEN  bus word address, bits [1:0] forced to 0; registered.
- i_BusAck  input  1  bus completion; i_BusData is valid in the same cycle.
- i_BusData  input  XLEN  bus read data.
- o_hit_cnt  output  32  refills served from the buffer; saturating.
- o_miss_cnt  output  32  refills requiring a demand bus access; saturating.

## Operation
- Buffer state: buf_valid, buf_addr, buf_data.
- A refill request hits when buf_valid=1, buf_addr[XLEN-1:2]=i_Addr[XLEN-1:2], and i_flush=0.

State machine states: IDLE, DEMAND, PREFETCH, RESP.
- IDLE:
  - i_DataReq with a hit: go to RESP with o_Data=buf_data; o_hit_cnt+1.
  - i_DataReq with a miss: go to DEMAND with o_BusAddr=i_Addr; o_miss_cnt+1.
  - i_DataReq is sampled only in IDLE and PREFETCH.
- DEMAND:
  - o_BusReq=1 and o_BusAddr are held until i_BusAck.
  - On ack: latch i_BusData into o_Data, clear buf_valid, go to RESP.
- RESP:
  - o_MemReady=1 for exactly one cycle.
  - Next state is PREFETCH with o_BusAddr = served address + 4, modulo 2^XLEN (0xFFFFFFFC wraps to 0x00000000).
  - If PREFETCH_EN=0, next state is IDLE.
- PREFETCH:
  - o_BusReq=1 is held until ack; the request is never abandoned.
  - On ack, unless a flush occurred during this transaction: load the buffer (valid, address, data).
  - If i_DataReq=1 and the prefetch address matches in the ack cycle: forward i_BusData, go to RESP, o_hit_cnt+1.
  - Otherwise go to IDLE, where the pending request is re-evaluated.
- Flush:
  - Clears buf_valid immediately.
  - During PREFETCH, sets a drop flag: the returning data is neither buffered nor forwarded, and the state goes to IDLE.
  - A demand access in progress is unaffected.
- Simultaneous flush and hit in IDLE: flush wins, the request is treated as a miss.
- Counters stop at 0xFFFFFFFF.

## Timing
Reset values (applied asynchronously, on assertion):
- State = IDLE.
- o_MemReady=0, o_Data=0, o_BusReq=0, o_BusAddr=0.
- buf_valid=0, drop flag=0, both counters 0.
- Reset during a bus transaction drops o_BusReq immediately; the bus must tolerate an abandoned request.

Latencies:
- Buffer hit: request seen in IDLE at cycle 0; o_MemReady at cycle 1.
- Miss: request at cycle 0; o_BusReq rises at cycle 1; ack at cycle k≥1; o_MemReady at cycle k+1. The minimum is 2 cycles (ack in the same cycle o_BusReq first rises).
- Prefetch forward: ack at cycle k; o_MemReady at cycle k+1.
- After a miss, a request arriving during PREFETCH that mismatches waits for the prefetch ack, spends one cycle in IDLE, then enters DEMAND.

Handshake rules:
- o_BusAddr is stable for the whole time o_BusReq=1.
- At most one outstanding bus transaction.
- o_BusReq falls in the cycle after the ack unless the next state issues a new request.

## Test plan
- Reset mid-DEMAND: assert i_rst asynchronously -> o_BusReq=0, o_MemReady=0, both counters 0 without waiting for a clock edge.
- Cold miss: request 0x100, ack 3 cycles after o_BusReq rises with 0xDEADBEEF -> o_MemReady one cycle later with o_Data=0xDEADBEEF; o_miss_cnt=1; then o_BusReq with o_BusAddr=0x104.
- Sequential hit: after the previous case, prefetch of 0x104 acked with 0x11111111, then request 0x104 in IDLE -> o_MemReady next cycle with 0x11111111; o_hit_cnt=1; next o_BusAddr=0x108.
- Forward: request 0x108 issued while the 0x108 prefetch is pending; ack with 0x22 -> o_MemReady next cycle with o_Data=0x22; hit counted; no demand access.
- Flush: i_flush during the 0x10C prefetch, then request 0x10C -> miss; DEMAND issued to 0x10C; o_miss_cnt increments.
- Wrap and disable: a miss at 0xFFFFFFFC -> prefetch o_BusAddr=0x00000000. With PREFETCH_EN=0, o_BusReq is never asserted after RESP, and o_hit_cnt stays 0.
